// File: rtl/ram_sp_init.sv
// ram_sp_init: single-port RAM with active-low enables, bit-write mask, post-reset
// fill engine, selectable read latency and write-port read mode.
module ram_sp_init #(
  parameter int                DATA_W   = 64,
  parameter int                DEPTH    = 4096,
  parameter int                ADDR_W   = 12,
  parameter int                RD_LAT   = 1,
  parameter int                WR_MODE  = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ceb,
  input  logic              web,
  input  logic [DATA_W-1:0] bweb,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              init_done_o
);
  typedef enum logic {INIT, READY} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] s1_dat_q, s1_dat_d, data_q, data_d, old, merged, res;
  logic s1_vld_q, s1_vld_d, vld_q, vld_d, acc, in_rng, res_vld;
  assign acc     = state_q == READY && !ceb;
  assign in_rng  = 32'(addr_i) < DEPTH;
  assign old     = in_rng ? mem[addr_i] : '0;
  assign merged  = (data_i & ~bweb) | (old & bweb);
  assign res_vld = acc && (web || WR_MODE != 0);
  assign res     = (!web && WR_MODE == 2) ? merged : old;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    if (state_q == INIT) begin
      cnt_d   = cnt_q + 1'b1;
      state_d = (cnt_q == ADDR_W'(DEPTH - 1)) ? READY : INIT;
    end
    s1_vld_d = res_vld;
    s1_dat_d = res;
    vld_d    = (RD_LAT == 2) ? s1_vld_q : res_vld;
    data_d   = vld_d ? ((RD_LAT == 2) ? s1_dat_q : res) : data_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= INIT;
      cnt_q    <= '0;
      s1_vld_q <= 1'b0;
      s1_dat_q <= '0;
      vld_q    <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      s1_vld_q <= s1_vld_d;
      s1_dat_q <= s1_dat_d;
      vld_q    <= vld_d;
      data_q   <= data_d;
    end
  end
  // Masked write is done as a read-modify-write of the whole word.
  always_ff @(posedge clk) begin
    if (state_q == INIT) mem[cnt_q] <= INIT_VAL;
    else if (acc && !web && in_rng) mem[addr_i] <= merged;
  end
  assign data_o      = data_q;
  assign valid_o     = vld_q;
  assign init_done_o = state_q == READY;
endmodule

// File: tb/tb_ram_sp_init.sv
// tb_ram_sp_init: three RAM variants driven in parallel, checked by a queue scoreboard.
module tb_ram_sp_init;
  localparam int N = 3, DEPTH = 12;
  localparam int LAT [N] = '{1, 2, 1};
  localparam int WM  [N] = '{1, 2, 0};
  localparam logic [63:0] IV [N] = '{64'hA5A5_A5A5_A5A5_A5A5, 64'h0, 64'h0};
  typedef struct {int due; logic [63:0] d;} exp_t;
  logic clk = 0, rst = 0, ceb = 1, web = 1;
  logic [63:0] bweb = '1, din = '0;
  logic [3:0] addr = '0;
  logic [63:0] dout [N];
  logic vld [N], done [N];
  int cyc = 0, rdy_at = 1 << 30, total = 0, bad = 0;
  exp_t q [N][$];
  exp_t e;
  logic [63:0] mdl [N][DEPTH];
  logic [63:0] last [N];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  genvar g;
  generate for (g = 0; g < N; g++) begin : gd
    ram_sp_init #(.DATA_W(64), .DEPTH(DEPTH), .ADDR_W(4), .RD_LAT(LAT[g]),
                  .WR_MODE(WM[g]), .INIT_VAL(IV[g])) u (
      .clk(clk), .rst(rst), .ceb(ceb), .web(web), .bweb(bweb), .addr_i(addr),
      .data_i(din), .data_o(dout[g]), .valid_o(vld[g]), .init_done_o(done[g]));
  end endgenerate
  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d cyc=%0d got=%h want=%h", nm, k, cyc, act, exp);
    end
  endtask
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      chk("init_done", k, 64'(done[k]), 64'(rst && cyc >= rdy_at));
      while (q[k].size() > 0 && q[k][0].due < cyc) begin
        total++; bad++;
        $display("FAIL missing_valid inst%0d cyc=%0d got=none want=%h", k, cyc, q[k][0].d);
        void'(q[k].pop_front());
      end
      if (!rst) begin
        last[k] = '0;
        chk("rst_data", k, dout[k], 64'h0);
        chk("rst_valid", k, 64'(vld[k]), 64'h0);
      end else if (vld[k]) begin
        if (q[k].size() > 0 && q[k][0].due == cyc) begin
          e = q[k].pop_front();
          chk("data", k, dout[k], e.d);
          last[k] = e.d;
        end else begin
          total++; bad++;
          $display("FAIL spurious_valid inst%0d cyc=%0d got=%h want=no_valid", k, cyc, dout[k]);
        end
      end else chk("hold", k, dout[k], last[k]);
    end
  end
  task automatic acc(input logic w, input logic [3:0] a, input logic [63:0] d, input logic [63:0] b);
    logic [63:0] old, mg;
    @(posedge clk); #2;
    ceb = 0; web = w; addr = a; din = d; bweb = b;
    if (rst && cyc >= rdy_at)
      for (int k = 0; k < N; k++) begin
        old = (a < DEPTH) ? mdl[k][a] : 64'h0;
        mg  = (d & ~b) | (old & b);
        if (w) q[k].push_back('{cyc + LAT[k], old});
        else begin
          if (WM[k] != 0) q[k].push_back('{cyc + LAT[k], WM[k] == 1 ? old : mg});
          if (a < DEPTH) mdl[k][a] = mg;
        end
      end
  endtask
  task automatic idle();
    @(posedge clk); #2;
    ceb = 1;
  endtask
  task automatic rst_on();
    @(posedge clk); #2;
    rst = 0; ceb = 1; rdy_at = 1 << 30;
    for (int k = 0; k < N; k++) q[k].delete();
  endtask
  task automatic rel();
    @(posedge clk); #2;
    rst = 1; ceb = 1; rdy_at = cyc + DEPTH;
    for (int k = 0; k < N; k++) for (int i = 0; i < DEPTH; i++) mdl[k][i] = IV[k];
  endtask
  task automatic wait_ready();
    while (cyc < rdy_at) idle();
  endtask
  task automatic read_all();
    for (int i = 0; i < 16; i++) acc(1, 4'(i), 64'h0, '1);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge clk);
    rel();
    for (int i = 0; i < 5; i++) acc(1, 4'(i), 64'h0, '1);
    wait_ready();
    read_all();
    acc(0, 4'd3, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_0000_0000);
    acc(1, 4'd3, 64'h0, '1);
    acc(0, 4'd7, 64'h1111, 64'h0);
    acc(0, 4'd7, 64'h2222, 64'h0);
    acc(1, 4'd5, 64'h0, '1);
    acc(1, 4'd6, 64'h0, '1);
    acc(1, 4'd7, 64'h0, '1);
    idle();
    acc(0, 4'd13, 64'hFF, 64'h0);
    acc(1, 4'd13, 64'h0, '1);
    acc(0, 4'd9, 64'hDEAD_BEEF, '1);
    read_all();
    for (int i = 0; i < 400; i++) begin
      logic [63:0] b;
      case ($urandom_range(0, 2))
        0: b = '1;
        1: b = '0;
        default: b = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 7) == 0) idle();
      else acc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), {$urandom, $urandom}, b);
    end
    read_all();
    rst_on();
    rel();
    repeat (5) idle();
    rst_on();
    idle();
    rel();
    wait_ready();
    read_all();
    for (int i = 0; i < DEPTH; i++) acc(0, 4'(i), {$urandom, $urandom}, 64'h0);
    acc(1, 4'd2, 64'h0, '1);
    rst_on();
    rel();
    wait_ready();
    read_all();
    repeat (6) idle();
    for (int k = 0; k < N; k++) chk("queue_drained", k, 64'(q[k].size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
